// File: rtl/cpu_control_unit_if.sv
// Instruction- and data-memory handshake bundle for cpu_control_unit.
// The control unit is the master (it raises the requests); the memories
// are slaves (they answer with acknowledges and fetch data).
interface cpu_control_unit_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 8-bit pseudo-processor.
// Owns the PC and walks FETCH -> DECODE -> EXEC -> (MEM) -> WB, issuing the
// datapath strobes. Decoder fields (opcode/rd/rs/imm2/imm4) come from an
// external registered decoder fed by ir; they settle at EXEC entry and stay
// stable until the next instruction is decoded.
// Optional feature: define CTRL_TIMEOUT_EN to abort a request that waits
// ACK_TIMEOUT cycles for its acknowledge, entering the sticky FAULT state.
module cpu_control_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_control_unit_if.master  bus,
    output logic [7:0]          ir,
    input  logic [3:0]          opcode,
    input  logic [1:0]          rd,
    input  logic [1:0]          rs,
    input  logic [1:0]          imm2,
    input  logic [3:0]          imm4,
    input  logic                zero_flag,
    output logic [1:0]          rf_raddr_a,
    output logic [1:0]          rf_raddr_b,
    output logic                rf_we,
    output logic [1:0]          rf_waddr,
    output logic [1:0]          wb_sel,
    output logic [3:0]          alu_op,
    output logic                alu_src_imm,
    output logic                flags_we,
    output logic [7:0]          pc,
    output logic                halted,
    output logic                fault
);

`ifdef CTRL_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    localparam logic [3:0] OP_JMP  = 4'h0;
    localparam logic [3:0] OP_JZ   = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_LD   = 4'hD;
    localparam logic [3:0] OP_ST   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] pc_r;
    logic [7:0] pc_next_s;
    logic [7:0] ir_r;
    logic [7:0] wait_cnt_r;
    logic       imem_req_r;
    logic       dmem_req_r;
    logic       dmem_we_r;
    logic       rf_we_r;
    logic [1:0] rf_waddr_r;
    logic [1:0] wb_sel_r;
    logic       halted_r;
    logic       fault_r;

    logic       fetch_done_s;
    logic       mem_done_s;
    logic       wait_active_s;
    logic       timeout_hit_s;
    logic [7:0] pc_inc_s;
    logic [7:0] pc_rel_s;
    logic [1:0] wb_sel_s;

    assign fetch_done_s  = (state_r == ST_FETCH) && imem_req_r && bus.imem_ack;
    assign mem_done_s    = (state_r == ST_MEM) && dmem_req_r && bus.dmem_ack;
    assign wait_active_s = ((state_r == ST_FETCH) && imem_req_r) ||
                           ((state_r == ST_MEM) && dmem_req_r);
    assign timeout_hit_s = TIMEOUT_EN && wait_active_s && !fetch_done_s &&
                           !mem_done_s && (wait_cnt_r == TIMEOUT_LAST);
    assign pc_inc_s      = pc_r + 8'd1;
    assign pc_rel_s      = pc_r + {{4{imm4[3]}}, imm4};

    // Next-state and next-PC selection for the instruction sequencer.
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            ST_FETCH: begin
                if (fetch_done_s) begin
                    next_state_s = ST_DECODE;
                end else if (timeout_hit_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                next_state_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_JMP: begin
                        next_state_s = ST_FETCH;
                        pc_next_s    = pc_rel_s;
                    end
                    OP_JZ: begin
                        next_state_s = ST_FETCH;
                        if (zero_flag) begin
                            pc_next_s = pc_rel_s;
                        end else begin
                            pc_next_s = pc_inc_s;
                        end
                    end
                    OP_CMP: begin
                        next_state_s = ST_FETCH;
                        pc_next_s    = pc_inc_s;
                    end
                    OP_HALT: next_state_s = ST_HALT;
                    OP_LD:   next_state_s = ST_MEM;
                    OP_ST:   next_state_s = ST_MEM;
                    default: next_state_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_done_s) begin
                    if (opcode == OP_ST) begin
                        next_state_s = ST_FETCH;
                        pc_next_s    = pc_inc_s;
                    end else begin
                        next_state_s = ST_WB;
                    end
                end else if (timeout_hit_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                next_state_s = ST_FETCH;
                pc_next_s    = pc_inc_s;
            end
            ST_HALT:  next_state_s = ST_HALT;
            ST_FAULT: next_state_s = ST_FAULT;
            default:  next_state_s = ST_FETCH;
        endcase
    end

    // Write-back source for the instruction currently in flight.
    always_comb begin
        wb_sel_s = 2'd0;
        case (opcode)
            OP_LDI:  wb_sel_s = 2'd1;
            OP_LD:   wb_sel_s = 2'd2;
            OP_MOV:  wb_sel_s = 2'd3;
            default: wb_sel_s = 2'd0;
        endcase
    end

    // EXEC-phase controls decode straight from the state register and the
    // decoder fields, because those fields only become valid on EXEC entry.
    always_comb begin
        alu_op      = 4'd0;
        alu_src_imm = 1'b0;
        flags_we    = 1'b0;
        if (state_r == ST_EXEC) begin
            alu_op = opcode;
            case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: flags_we = 1'b1;
                OP_ADDI, OP_SHL, OP_SHR: begin
                    flags_we    = 1'b1;
                    alu_src_imm = 1'b1;
                end
                default: flags_we = 1'b0;
            endcase
        end else begin
            alu_op = 4'd0;
        end
    end

    // Register read ports follow the decoded instruction outside FETCH.
    always_comb begin
        rf_raddr_a = 2'd0;
        rf_raddr_b = 2'd0;
        if ((state_r != ST_FETCH) && (state_r != ST_HALT) && (state_r != ST_FAULT)) begin
            rf_raddr_a = rd;
            if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                rf_raddr_b = imm2;
            end else begin
                rf_raddr_b = rs;
            end
        end else begin
            rf_raddr_a = 2'd0;
        end
    end

    // State, PC, instruction register and acknowledge-wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            ir_r       <= 8'h00;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r <= next_state_s;
            pc_r    <= pc_next_s;
            if (fetch_done_s) begin
                ir_r <= bus.imem_rdata;
            end
            if (wait_active_s && !fetch_done_s && !mem_done_s) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
        end
    end

    // Handshake and write-back strobes are registered from the next state so
    // they line up with the state they belong to and drop on reset at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 2'd0;
            wb_sel_r   <= 2'd0;
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            imem_req_r <= (next_state_s == ST_FETCH);
            dmem_req_r <= (next_state_s == ST_MEM);
            dmem_we_r  <= (next_state_s == ST_MEM) && (opcode == OP_ST);
            rf_we_r    <= (next_state_s == ST_WB);
            rf_waddr_r <= (next_state_s == ST_WB) ? rd : 2'd0;
            wb_sel_r   <= (next_state_s == ST_WB) ? wb_sel_s : 2'd0;
            halted_r   <= (next_state_s == ST_HALT);
            fault_r    <= (next_state_s == ST_FAULT);
        end
    end

    assign bus.imem_req  = imem_req_r;
    assign bus.imem_addr = pc_r;
    assign bus.dmem_req  = dmem_req_r;
    assign bus.dmem_we   = dmem_we_r;
    assign ir            = ir_r;
    assign pc            = pc_r;
    assign rf_we         = rf_we_r;
    assign rf_waddr      = rf_waddr_r;
    assign wb_sel        = wb_sel_r;
    assign halted        = halted_r;
    assign fault         = fault_r;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: models the registered decoder and the
// memories, drives short programs and compares against hand-computed values.
module tb_cpu_control_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] ir;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] imm2;
    logic [3:0] imm4;
    logic       zero_flag;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       flags_we;
    logic [7:0] pc;
    logic       halted;
    logic       fault;

    logic [7:0] imem [256];
    int         check_cnt;
    int         error_cnt;
    int         cyc;

`ifdef CTRL_TIMEOUT_EN
    localparam int   EXP_WAIT_REQ = 15;
    localparam logic EXP_FAULT    = 1'b1;
    localparam logic EXP_REQ_END  = 1'b0;
`else
    localparam int   EXP_WAIT_REQ = 40;
    localparam logic EXP_FAULT    = 1'b0;
    localparam logic EXP_REQ_END  = 1'b1;
`endif

    cpu_control_unit_if bus ();

    cpu_control_unit #(.RESET_PC(8'h10), .ACK_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ir          (ir),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .imm2        (imm2),
        .imm4        (imm4),
        .zero_flag   (zero_flag),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .flags_we    (flags_we),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault)
    );

    assign bus.imem_rdata = imem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure instruction latencies.
    always @(posedge clk) cyc <= cyc + 1;

    // Registered instruction decoder model feeding the control unit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode <= 4'd0; rd <= 2'd0; rs <= 2'd0; imm2 <= 2'd0; imm4 <= 4'd0;
        end else begin
            opcode <= ir[7:4]; rd <= ir[3:2]; rs <= ir[1:0];
            imm2   <= ir[1:0]; imm4 <= ir[3:0];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle with imem_req high and check its address.
    task automatic next_fetch(input string tag, input logic [7:0] exp_addr, output int at_cyc);
        bit         seen;
        logic [7:0] addr;
        seen   = 1'b0;
        addr   = 8'h00;
        at_cyc = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                seen   = 1'b1;
                addr   = bus.imem_addr;
                at_cyc = cyc;
                break;
            end
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        check_eq(tag, 32'(addr), 32'(exp_addr));
    endtask

    logic [7:0]  exp_req_tab;
    logic [7:0]  exp_we_tab;
    logic [7:0]  exp_fl_tab;
    logic [15:0] exp_sel_tab;
    logic [15:0] exp_wa_tab;
    int          t0;
    int          t1;
    int          held;
    int          busy;

    initial begin
        check_cnt = 0; error_cnt = 0; cyc = 0;
        rst_n = 1'b0; zero_flag = 1'b1;
        bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
        for (int a = 0; a < 256; a++) imem[a] = 8'hF0;
        imem[8'h10] = 8'h26;  // LDI R1,2
        imem[8'h11] = 8'h45;  // ADD R1,R1
        imem[8'h12] = 8'h08;  // JMP -8  -> 0A
        imem[8'h0A] = 8'h08;  // JMP -8  -> 02
        imem[8'h02] = 8'h0E;  // JMP -2  -> 00
        imem[8'h00] = 8'hA0;  // CMP     -> 01
        imem[8'h01] = 8'h1E;  // JZ -2   -> FF / 02
        imem[8'hFF] = 8'hD9;  // LD R2,[R1] -> wraps to 00

        // Reset values.
        @(negedge clk);
        check_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'h10);
        check_eq("rst_ir", 32'(ir), 32'h00);
        check_eq("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check_eq("rst_strobes", {28'd0, rf_we, flags_we, halted, fault}, 32'd0);
        check_eq("rst_wb_alu", {26'd0, wb_sel, alu_op}, 32'd0);
        check_eq("rst_raddr", {28'd0, rf_raddr_a, rf_raddr_b}, 32'd0);

        // LDI R1,2 then ADD R1,R1 with zero-wait fetch: cycle-by-cycle table.
        exp_req_tab = 8'b0001_0001;
        exp_we_tab  = 8'b1000_1000;
        exp_fl_tab  = 8'b0100_0000;
        exp_sel_tab = {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        exp_wa_tab  = {2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("c%0d_imem_req", i), 32'(bus.imem_req), 32'(exp_req_tab[i-1]));
            check_eq($sformatf("c%0d_rf_we", i), 32'(rf_we), 32'(exp_we_tab[i-1]));
            check_eq($sformatf("c%0d_flags_we", i), 32'(flags_we), 32'(exp_fl_tab[i-1]));
            check_eq($sformatf("c%0d_wb_sel", i), 32'(wb_sel), 32'(exp_sel_tab[2*(i-1) +: 2]));
            check_eq($sformatf("c%0d_rf_waddr", i), 32'(rf_waddr), 32'(exp_wa_tab[2*(i-1) +: 2]));
            if (i == 1) check_eq("first_fetch_addr", 32'(bus.imem_addr), 32'h10);
            if (i == 2) check_eq("ir_ldi", 32'(ir), 32'h26);
            if (i == 7) begin
                check_eq("add_alu_op", 32'(alu_op), 32'h4);
                check_eq("add_raddr", {28'd0, rf_raddr_a, rf_raddr_b}, 32'b0101);
                check_eq("add_src_imm", 32'(alu_src_imm), 32'd0);
            end
        end

        // Relative jumps, CMP and JZ taken with wrap below zero.
        next_fetch("fetch_12", 8'h12, t0);
        next_fetch("fetch_0a", 8'h0A, t1);
        check_eq("jmp_latency", 32'(t1 - t0), 32'd3);
        next_fetch("fetch_02", 8'h02, t0);
        next_fetch("fetch_00", 8'h00, t0);
        next_fetch("fetch_01", 8'h01, t1);
        check_eq("cmp_latency", 32'(t1 - t0), 32'd3);
        next_fetch("jz_taken_ff", 8'hFF, t0);

        // LD R2 at FF with dmem_ack arriving on the fourth request cycle.
        held = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dmem_req) break;
        end
        check_eq("ld_dmem_we", 32'(bus.dmem_we), 32'd0);
        check_eq("ld_raddr_b", 32'(rf_raddr_b), 32'd1);
        for (int k = 0; k < 20; k++) begin
            if (bus.dmem_req) begin
                held++;
                if (held == 4) bus.dmem_ack = 1'b1;
            end else begin
                break;
            end
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        check_eq("ld_req_held", 32'(held), 32'd4);
        check_eq("ld_wb_rf_we", 32'(rf_we), 32'd1);
        check_eq("ld_wb_sel", 32'(wb_sel), 32'd2);
        check_eq("ld_wb_waddr", 32'(rf_waddr), 32'd2);

        // PC wraps FF -> 00, then JZ not taken.
        zero_flag = 1'b0;
        next_fetch("wrap_00", 8'h00, t0);
        next_fetch("fetch_01b", 8'h01, t0);
        next_fetch("jz_not_taken", 8'h02, t0);

        // Asynchronous reset mid-fetch drops the request immediately.
        rst_n = 1'b0;
        #1;
        check_eq("async_req_drop", 32'(bus.imem_req), 32'd0);
        check_eq("async_pc", 32'(pc), 32'h10);
        imem[8'h10] = 8'hE4;  // ST R1,[R0]
        imem[8'h11] = 8'hF0;  // HALT
        bus.dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ST with zero-wait ack, then HALT.
        next_fetch("st_fetch", 8'h10, t0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.dmem_req) break;
        end
        check_eq("st_dmem_we", 32'(bus.dmem_we), 32'd1);
        next_fetch("halt_fetch", 8'h11, t1);
        check_eq("st_latency", 32'(t1 - t0), 32'd4);
        repeat (4) @(negedge clk);
        check_eq("halted", 32'(halted), 32'd1);
        busy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.imem_req || bus.dmem_req || rf_we) busy++;
        end
        check_eq("halt_quiet", 32'(busy), 32'd0);
        check_eq("halt_sticky", 32'(halted), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("halt_cleared", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_fetch("restart", 8'h10, t0);

        // Acknowledge withheld: timeout behaviour depends on the build.
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.imem_req) busy++;
        end
        check_eq("wait_req_cycles", 32'(busy), 32'(EXP_WAIT_REQ));
        check_eq("wait_fault", 32'(fault), 32'(EXP_FAULT));
        check_eq("wait_req_end", 32'(bus.imem_req), 32'(EXP_REQ_END));

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle sequencer for the 8-bit pseudo-processor: owns the program counter, runs the FETCH -> DECODE -> EXEC -> (MEM) -> WB cycle, and issues all datapath control strobes. It fetches each instruction byte over a req/ack handshake and hands it to the registered `instruction_decoder`. It then consumes the decoder's `opcode`/`Rd`/`Rs`/`imm2`/`imm4` fields to drive the register file, ALU, flags and data-memory handshake.

## Interface
- `RESET_PC`, 8'h00, PC value loaded on reset
- `ACK_TIMEOUT`, 15, cycles a request may wait for ack before FAULT (used only with `CTRL_TIMEOUT_EN`)
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req` / `imem_addr`  out  1 / 8  instruction fetch request; address = PC
- `imem_ack` / `imem_rdata`  in  1 / 8  fetch acknowledge; instruction byte valid with ack
- `ir`  out  8  instruction register, feeds decoder `ip1`
- `opcode` / `rd` / `rs` / `imm2` / `imm4`  in  4 / 2 / 2 / 2 / 4  decoder outputs
- `zero_flag`  in  1  datapath Z flag
- `rf_raddr_a` / `rf_raddr_b`  out  2 / 2  register read ports
- `rf_we` / `rf_waddr`  out  1 / 2  register write strobe and address
- `wb_sel`  out  2  write-back source: 0 ALU, 1 immediate, 2 data memory, 3 port B
- `alu_op`  out  4  equals latched opcode during EXEC
- `alu_src_imm`  out  1  ALU operand B = zero-extended imm2
- `flags_we`  out  1  one-cycle strobe updating Z
- `dmem_req` / `dmem_we` / `dmem_ack`  out / out / in  1 / 1 / 1  data-memory handshake; address = port A data, write data = port B data
- `pc`  out  8  current program counter
- `halted` / `fault`  out  1 / 1  sticky status

## Operation
- ISA: 0000 JMP, PC += sext(imm4). 0001 JZ, taken iff `zero_flag`. 0010 LDI, Rd = imm2. 0011 MOV, Rd = Rs. 0100 ADD. 0101 SUB. 0110 AND. 0111 OR. 1000 XOR. 1001 ADDI. 1010 CMP, flags only. 1011 SHL by imm2. 1100 SHR by imm2. 1101 LD, Rd = mem[R(imm2)]. 1110 ST, mem[R(imm2)] = Rd. 1111 HALT.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- FETCH: hold `imem_req`=1 with `imem_addr`=pc until `imem_ack`. On ack, latch `ir` = `imem_rdata` and go to DECODE.
- DECODE: exactly 1 cycle, covering the decoder's register stage. Drive `rf_raddr_a`=rd; `rf_raddr_b`=rs for reg-reg ops, imm2 for LD/ST.
- EXEC:
  - ALU ops and ADDI/SHL/SHR pulse `flags_we`. `alu_src_imm`=1 for 1001/1011/1100.
  - CMP: pc += 1, then FETCH.
  - JMP/JZ-taken: pc = pc + sext(imm4), mod 256. JZ not taken: pc += 1. Both then go to FETCH.
  - HALT: go to HALT.
  - LD/ST: go to MEM. All other ops go to WB.
- MEM: hold `dmem_req`=1, with `dmem_we`=1 for ST, until `dmem_ack`. ST: pc += 1, then FETCH. LD: go to WB.
- WB: one-cycle `rf_we`=1 with `rf_waddr`=rd and `wb_sel` per op (LDI 1, MOV 3, LD 2, else 0). pc += 1, then FETCH.
- PC arithmetic is 8-bit and wraps: 8'hFF + 1 = 8'h00. JMP with imm4=4'hF from 8'h00 yields 8'hFF.
- HALT and FAULT are absorbing until reset. No requests are issued in either state.

## Timing
- Reset, asynchronous: state=FETCH, pc=`RESET_PC`, `ir`=0. Every strobe, req, `halted`, `fault`, `wb_sel`, `alu_op` and read address = 0.
- First `imem_req`=1 appears in the first cycle after `rst_n` deasserts.
- `imem_ack` and `dmem_ack` may arrive in the same cycle req rises. Req drops the cycle after ack is sampled.
- Ack while req=0 is ignored.
- Latency with zero-wait ack:
  - ALU/LDI/MOV: 4 cycles (F, D, E, W).
  - JMP/JZ/CMP: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- `rf_we`, `flags_we` and `dmem_req`/`imem_req` are never high together.
- Reset asserted mid-transaction drops req combinationally (async). No write strobe is issued for the aborted instruction.

## Configuration
- `CTRL_TIMEOUT_EN` defined: a 4+ bit counter runs while `imem_req` or `dmem_req` waits. When the wait reaches `ACK_TIMEOUT` cycles without ack, req drops next cycle, the block enters FAULT and `fault`=1.
- `CTRL_TIMEOUT_EN` undefined: the block waits indefinitely, `fault` is tied 0, and the FAULT state is unreachable.

## Test plan
- Reset release with `RESET_PC`=8'h10, ack tied high: `imem_addr`=8'h10 on the first req. The first fetch completes in 1 cycle.
- Program LDI R1,2 (8'h26); ADD R1,R1 (8'h45); zero-wait: `rf_we` pulses at cycles 4 and 8. `rf_waddr`=1 both times, with `wb_sel`=1 then 0.
- JZ imm4=4'hE at pc=8'h01 with `zero_flag`=1: next `imem_addr`=8'hFF. With `zero_flag`=0: next addr=8'h02.
- LD R2 (8'hD9) with `dmem_ack` delayed 3 cycles: `dmem_req` held 4 cycles, `dmem_we`=0. `rf_we` with `wb_sel`=2 the cycle after ack.
- HALT (8'hF0): `halted`=1, no further `imem_req` for 100 cycles. Pulsing `rst_n` low restarts at `RESET_PC`.
- With `CTRL_TIMEOUT_EN`, ack held low: `fault`=1 after 15 waiting cycles, and req drops. Without the macro: req stays high and `fault`=0.
